millis_alarm: RTL and testbench

- Memory-mapped millisecond alarm/timer peripheral.
- Consumes the free-running 32-bit `millis` count produced by the system millisecond counter.
- Lets RISC-V software arm one-shot or periodic deadlines in milliseconds and raises a level interrupt when a deadline is reached.
- Sits on the single-cycle core's data bus beside the other MMIO peripherals. Reads are combinational; writes commit on the clock edge.

---
 rtl/millis_alarm_if.sv | 29 ++
 rtl/millis_alarm.sv | 129 ++++++++++++
 tb/tb_millis_alarm.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/millis_alarm_if.sv
// Data-bus bundle between the core's MMIO decoder and the millisecond alarm.
// The core drives the request side; the peripheral returns read data and its
// interrupt level.
interface millis_alarm_if;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output sel,
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  sel,
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/millis_alarm.sv
// Millisecond alarm peripheral: software arms one-shot or periodic deadlines
// against the system millis count and receives a level interrupt when a
// deadline is reached. Reads are combinational, writes land on the clock edge.
module millis_alarm #(
    parameter int OVR_W = 8
) (
    input  logic           clk_25_mhz,
    input  logic           rst,
    input  logic [31:0]    millis,
    millis_alarm_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_INTERVAL = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_TARGET   = 2'd3;

    logic [0:0]       state;
    logic             ctrl_en;
    logic             ctrl_periodic;
    logic             ctrl_ie;
    logic [31:0]      interval;
    logic [31:0]      target;
    logic             fired;
    logic [OVR_W-1:0] ovr;

    logic             wr_access;
    logic             ctrl_wr;
    logic             interval_wr;
    logic             status_clr;
    logic [31:0]      since_target;
    logic             fire;
    logic [31:0]      reload_step;

    assign wr_access   = bus.sel && bus.we;
    assign ctrl_wr     = wr_access && (bus.addr[3:2] == REG_CTRL);
    assign interval_wr = wr_access && (bus.addr[3:2] == REG_INTERVAL);
    assign status_clr  = wr_access && (bus.addr[3:2] == REG_STATUS) && bus.wdata[0];

    // Wrap-safe reach test: the sign of (millis - target) tells whether the
    // deadline is at or behind us. A CTRL write in the same cycle takes
    // priority over a fire.
    assign since_target = millis - target;
    assign fire         = (state == ST_ARMED) && !since_target[31] && !ctrl_wr;

    // A zero interval in periodic mode would never advance, so step by 1 ms.
    assign reload_step  = (interval == 32'd0) ? 32'd1 : interval;

    // Control bits, arm/disarm state and deadline tracking.
    always_ff @(posedge clk_25_mhz) begin
        if (rst) begin
            state         <= ST_IDLE;
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_ie       <= 1'b0;
            target        <= 32'd0;
        end else if (ctrl_wr) begin
            ctrl_en       <= bus.wdata[0];
            ctrl_periodic <= bus.wdata[1];
            ctrl_ie       <= bus.wdata[2];
            if (bus.wdata[0]) begin
                target <= millis + interval;
                state  <= ST_ARMED;
            end else begin
                state  <= ST_IDLE;
            end
        end else if (fire) begin
            if (ctrl_periodic) begin
                target <= target + reload_step;
            end else begin
                ctrl_en <= 1'b0;
                state   <= ST_IDLE;
            end
        end
    end

    // Interval register; a new value is only picked up at the next arm or reload.
    always_ff @(posedge clk_25_mhz) begin
        if (rst) begin
            interval <= 32'd0;
        end else if (interval_wr) begin
            interval <= bus.wdata;
        end
    end

    // FIRED flag and saturating missed-event counter; a fire beats a clear.
    always_ff @(posedge clk_25_mhz) begin
        if (rst) begin
            fired <= 1'b0;
            ovr   <= '0;
        end else if (status_clr) begin
            fired <= fire;
            ovr   <= '0;
        end else if (fire) begin
            fired <= 1'b1;
            if (fired && (ovr != {OVR_W{1'b1}})) begin
                ovr <= ovr + 1'b1;
            end
        end
    end

    // Combinational register read mux, silent when not selected.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.sel) begin
            case (bus.addr[3:2])
                REG_CTRL: begin
                    bus.rdata[0] = ctrl_en;
                    bus.rdata[1] = ctrl_periodic;
                    bus.rdata[2] = ctrl_ie;
                end
                REG_INTERVAL: bus.rdata = interval;
                REG_STATUS: begin
                    bus.rdata[0]          = fired;
                    bus.rdata[1]          = (state == ST_ARMED);
                    bus.rdata[8 +: OVR_W] = ovr;
                end
                REG_TARGET: bus.rdata = target;
                default:    bus.rdata = 32'd0;
            endcase
        end
    end

    assign bus.irq = fired & ctrl_ie;

endmodule

// File: tb/tb_millis_alarm.sv
// Bench for millis_alarm: a table of directed vectors, hand-written sequences
// for the multi-cycle corners, then random bus traffic against a register-level
// reference model.
module tb_millis_alarm;

    logic        clk_25_mhz = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] millis = 32'd0;

    int checks = 0;
    int errors = 0;

    localparam int OVR_MAX = 255;

    millis_alarm_if bus ();

    millis_alarm #(.OVR_W(8)) dut (
        .clk_25_mhz (clk_25_mhz),
        .rst        (rst),
        .millis     (millis),
        .bus        (bus.slave)
    );

    always #20 clk_25_mhz = ~clk_25_mhz;

    // Reference model: the software-visible register state.
    logic        m_en, m_per, m_ie, m_fired, m_armed;
    logic [31:0] m_interval, m_target;
    int          m_ovr;

    typedef struct {
        logic        s;
        logic [3:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] m;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic s, input logic [3:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (s) begin
            case (a[3:2])
                2'd0: v = {29'd0, m_ie, m_per, m_en};
                2'd1: v = m_interval;
                2'd2: v = (32'(m_ovr) << 8) | {30'd0, m_armed, m_fired};
                default: v = m_target;
            endcase
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the rules of the register map.
    task automatic model_clock(input logic r, input logic s, input logic [3:0] a,
                               input logic w, input logic [31:0] d, input logic [31:0] m);
        bit ctrl_write, int_write, clear, due;
        if (r) begin
            m_en = 0; m_per = 0; m_ie = 0; m_fired = 0; m_armed = 0;
            m_interval = 0; m_target = 0; m_ovr = 0;
            return;
        end
        ctrl_write = s && w && (a[3:2] == 2'd0);
        int_write  = s && w && (a[3:2] == 2'd1);
        clear      = s && w && (a[3:2] == 2'd2) && d[0];
        due        = m_armed && !ctrl_write && (int'(m - m_target) >= 0);

        if (clear) begin
            m_fired = due;
            m_ovr   = 0;
        end else if (due) begin
            if (m_fired) m_ovr = (m_ovr == OVR_MAX) ? OVR_MAX : m_ovr + 1;
            m_fired = 1;
        end

        if (ctrl_write) begin
            m_en = d[0]; m_per = d[1]; m_ie = d[2];
            if (d[0]) begin
                m_target = m + m_interval;
                m_armed  = 1;
            end else begin
                m_armed  = 0;
            end
        end else if (due) begin
            if (m_per) begin
                m_target = m_target + ((m_interval == 0) ? 32'd1 : m_interval);
            end else begin
                m_armed = 0;
                m_en    = 0;
            end
        end

        if (int_write) m_interval = d;
    endtask

    // One bus cycle: drive after the falling edge, sample before the rising edge.
    task automatic step(input logic r, input logic s, input logic [3:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] m,
                        output logic [31:0] rd, output logic iq);
        rst       = r;
        bus.sel   = s;
        bus.addr  = a;
        bus.we    = w;
        bus.wdata = d;
        millis    = m;
        #1;
        rd = bus.rdata;
        iq = bus.irq;
        if (!r) begin
            check("model_rdata", rd, model_read(s, a));
            check("model_irq", {31'd0, iq}, {31'd0, m_ie & m_fired});
        end
        @(posedge clk_25_mhz);
        model_clock(r, s, a, w, d, m);
        @(negedge clk_25_mhz);
    endtask

    task automatic do_reset(input logic [31:0] m);
        logic [31:0] rd;
        logic iq;
        step(1'b1, 1'b0, 4'h0, 1'b0, 32'd0, m, rd, iq);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
        logic [31:0] rd;
        logic iq;
        step(1'b0, 1'b1, a, 1'b1, d, m, rd, iq);
    endtask

    task automatic rd_at(input logic [3:0] a, input logic [31:0] m,
                         output logic [31:0] rd, output logic iq);
        step(1'b0, 1'b1, a, 1'b0, 32'd0, m, rd, iq);
    endtask

    initial begin
        logic [31:0] rd;
        logic        iq;
        logic [31:0] exp_tgt[10];
        logic [31:0] m;

        bus.sel = 0; bus.addr = 0; bus.we = 0; bus.wdata = 0;
        @(negedge clk_25_mhz);
        do_reset(32'd0);
        do_reset(32'd0);

        // Reset values of every register.
        for (int i = 0; i < 4; i++) begin
            rd_at(4'(i * 4), 32'd0, rd, iq);
            check("reset_reg", rd, 32'd0);
        end
        check("reset_irq", {31'd0, iq}, 32'd0);

        // One-shot arm at millis=100 with INTERVAL=5.
        tbl[0] = '{1'b1, 4'h4, 1'b1, 32'd5, 32'd100, 32'd0,     1'b0};
        tbl[1] = '{1'b1, 4'h0, 1'b1, 32'h5, 32'd100, 32'd0,     1'b0};
        tbl[2] = '{1'b1, 4'hC, 1'b0, 32'd0, 32'd101, 32'd105,   1'b0};
        tbl[3] = '{1'b1, 4'h8, 1'b0, 32'd0, 32'd102, 32'h2,     1'b0};
        tbl[4] = '{1'b1, 4'h8, 1'b0, 32'd0, 32'd104, 32'h2,     1'b0};
        tbl[5] = '{1'b1, 4'h8, 1'b0, 32'd0, 32'd105, 32'h2,     1'b0};
        tbl[6] = '{1'b1, 4'h8, 1'b0, 32'd0, 32'd106, 32'h1,     1'b1};
        tbl[7] = '{1'b1, 4'h0, 1'b0, 32'd0, 32'd106, 32'h4,     1'b1};
        tbl[8] = '{1'b0, 4'h8, 1'b0, 32'd0, 32'd107, 32'h0,     1'b1};
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].m, rd, iq);
            check("tbl_rdata", rd, tbl[i].exp_rd);
            check("tbl_irq", {31'd0, iq}, {31'd0, tbl[i].exp_irq});
        end

        // Periodic: INTERVAL=3 from millis=10, fires at 13, 16, 19.
        do_reset(32'd10);
        wr(4'h4, 32'd3, 32'd10);
        wr(4'h0, 32'h7, 32'd10);
        exp_tgt = '{32'd13, 32'd13, 32'd13, 32'd16, 32'd16, 32'd16,
                    32'd19, 32'd19, 32'd19, 32'd22};
        for (int i = 0; i < 10; i++) begin
            rd_at(4'hC, 32'(11 + i), rd, iq);
            check("periodic_target", rd, exp_tgt[i]);
        end
        rd_at(4'h8, 32'd20, rd, iq);
        check("periodic_ovr", rd, 32'h203);
        check("periodic_irq", {31'd0, iq}, 32'd1);

        // W1C colliding with a fire at 22, then a quiet W1C at 24.
        rd_at(4'h8, 32'd21, rd, iq);
        wr(4'h8, 32'h1, 32'd22);
        rd_at(4'h8, 32'd23, rd, iq);
        check("w1c_collide", rd, 32'h3);
        wr(4'h8, 32'h1, 32'd24);
        rd_at(4'h8, 32'd25, rd, iq);
        check("w1c_quiet", rd, 32'h2);
        check("w1c_quiet_irq", {31'd0, iq}, 32'd0);

        // Deadline across the 32-bit wrap.
        do_reset(32'hFFFF_FFFE);
        wr(4'h4, 32'd4, 32'hFFFF_FFFE);
        wr(4'h0, 32'h1, 32'hFFFF_FFFE);
        rd_at(4'hC, 32'hFFFF_FFFF, rd, iq);
        check("wrap_target", rd, 32'h2);
        for (int i = 0; i < 3; i++) begin
            rd_at(4'h8, 32'(i), rd, iq);
            check("wrap_no_early_fire", rd, 32'h2);
        end
        rd_at(4'h8, 32'd3, rd, iq);
        check("wrap_fired", rd, 32'h1);

        // Disarm before the deadline; TARGET survives.
        do_reset(32'd1000);
        wr(4'h4, 32'd50, 32'd1000);
        wr(4'h0, 32'h1, 32'd1000);
        for (int i = 1001; i < 1010; i++) rd_at(4'h8, 32'(i), rd, iq);
        wr(4'h0, 32'h0, 32'd1010);
        for (int i = 1011; i <= 1100; i++) rd_at(4'h8, 32'(i), rd, iq);
        check("disarm_status", rd, 32'h0);
        rd_at(4'hC, 32'd1100, rd, iq);
        check("disarm_target", rd, 32'd1050);

        // IE gating, INTERVAL=0 one-shot, then reset while armed.
        do_reset(32'd500);
        wr(4'h4, 32'd0, 32'd500);
        wr(4'h0, 32'h1, 32'd500);
        rd_at(4'h8, 32'd501, rd, iq);
        check("zero_interval_armed", rd, 32'h2);
        rd_at(4'h8, 32'd502, rd, iq);
        check("ie0_fired", rd, 32'h1);
        check("ie0_irq", {31'd0, iq}, 32'd0);
        wr(4'h0, 32'h4, 32'd502);
        rd_at(4'h0, 32'd503, rd, iq);
        check("ie1_ctrl", rd, 32'h4);
        check("ie1_irq", {31'd0, iq}, 32'd1);
        wr(4'h4, 32'd100, 32'd503);
        wr(4'h0, 32'h5, 32'd503);
        rd_at(4'h8, 32'd504, rd, iq);
        check("rearm_status", rd, 32'h3);
        do_reset(32'd505);
        for (int i = 0; i < 4; i++) begin
            rd_at(4'(i * 4), 32'd506, rd, iq);
            check("midrst_reg", rd, 32'd0);
        end
        check("midrst_irq", {31'd0, iq}, 32'd0);

        // Random traffic against the model, starting near the wrap point.
        m = 32'hFFFF_FF00;
        do_reset(m);
        for (int i = 0; i < 4000; i++) begin
            logic        r, s, w;
            logic [3:0]  a;
            logic [31:0] d;
            m = m + 32'($urandom_range(0, 1));
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 4) == 0);
            a = 4'($urandom_range(0, 15));
            d = $urandom();
            if (a[3:2] == 2'd1) d = 32'($urandom_range(0, 6));
            if (a[3:2] == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            step(r, s, a, w, d, m, rd, iq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
